// File: rtl/ddr3_axi_sched.sv
// DDR3 command scheduler: arbitrates AXI AW/AR bursts into 16-byte memory commands and returns B.
// Optional macro DDR3_SCHED_WRITE_PRIORITY_EN gives writes fixed priority over reads.
module ddr3_axi_sched #(
  parameter int WIDTH      = 32,
  parameter int RD_CREDITS = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             axi_awvalid_i,
  output logic             axi_awready_o,
  input  logic [WIDTH-1:0] axi_awaddr_i,
  input  logic [3:0]       axi_awid_i,
  input  logic [7:0]       axi_awlen_i,
  input  logic             axi_arvalid_i,
  output logic             axi_arready_o,
  input  logic [WIDTH-1:0] axi_araddr_i,
  input  logic [3:0]       axi_arid_i,
  input  logic [7:0]       axi_arlen_i,
  output logic             axi_bvalid_o,
  input  logic             axi_bready_i,
  output logic [1:0]       axi_bresp_o,
  output logic [3:0]       axi_bid_o,
  input  logic             wdat_ready_i,
  input  logic             rd_free_i,
  output logic             ram_wren_o,
  output logic             ram_rden_o,
  input  logic             ram_accept_i,
  input  logic             ram_error_i,
  output logic [3:0]       ram_req_id_o,
  output logic [WIDTH-1:0] ram_addr_o
);

  localparam int CW = $clog2(RD_CREDITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_BRESP, ST_READ} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;  // 1: previous grant went to the read side
  logic [WIDTH-1:0] addr_reg;
  logic [3:0]       id_reg;
  logic [9:0]       count_reg;
  logic [CW-1:0]    credits_reg;
  logic             err_reg;

  logic             grant_w, grant_r, prefer_w;
  logic             cmd_fire, rd_take;
  logic [9:0]       cmd_count_w, cmd_count_r;
  logic             unused_addr_bits;

  // Commands needed to cover the burst, counting from the 16-byte chunk holding the start beat.
  assign cmd_count_w = ((10'(axi_awaddr_i[3:2]) + 10'(axi_awlen_i)) >> 2) + 10'd1;
  assign cmd_count_r = ((10'(axi_araddr_i[3:2]) + 10'(axi_arlen_i)) >> 2) + 10'd1;
  assign unused_addr_bits = ^{axi_awaddr_i[1:0], axi_araddr_i[1:0]};

`ifdef DDR3_SCHED_WRITE_PRIORITY_EN
  assign prefer_w = 1'b1;
`else
  assign prefer_w = last_grant_reg;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_w       = 1'b0;
    grant_r       = 1'b0;
    ram_wren_o    = 1'b0;
    ram_rden_o    = 1'b0;
    axi_bvalid_o  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Gated by reset so no handshake is offered that the registers would then drop.
        if (!reset) begin
          if (axi_awvalid_i && (!axi_arvalid_i || prefer_w)) begin
            grant_w = 1'b1;
          end else if (axi_arvalid_i) begin
            grant_r = 1'b1;
          end
        end
        if (grant_w) begin
          state_next = ST_WRITE;
        end else if (grant_r) begin
          state_next = ST_READ;
        end
      end
      ST_WRITE: begin
        ram_wren_o = wdat_ready_i;
        if (wdat_ready_i && ram_accept_i && count_reg == 10'd1) begin
          state_next = ST_BRESP;
        end
      end
      ST_BRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        ram_rden_o = (credits_reg != '0);
        if ((credits_reg != '0) && ram_accept_i && count_reg == 10'd1) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign axi_awready_o = grant_w;
  assign axi_arready_o = grant_r;
  assign cmd_fire      = (ram_wren_o | ram_rden_o) & ram_accept_i;
  assign rd_take       = ram_rden_o & ram_accept_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg       <= '0;
      id_reg         <= '0;
      count_reg      <= '0;
      last_grant_reg <= 1'b1;
      err_reg        <= 1'b0;
      credits_reg    <= CW'(RD_CREDITS);
    end else begin
      if (grant_w) begin
        addr_reg       <= {axi_awaddr_i[WIDTH-1:4], 4'b0000};
        id_reg         <= axi_awid_i;
        count_reg      <= cmd_count_w;
        last_grant_reg <= 1'b0;
      end else if (grant_r) begin
        addr_reg       <= {axi_araddr_i[WIDTH-1:4], 4'b0000};
        id_reg         <= axi_arid_i;
        count_reg      <= cmd_count_r;
        last_grant_reg <= 1'b1;
      end else if (cmd_fire) begin
        addr_reg  <= addr_reg + WIDTH'(16);
        count_reg <= count_reg - 10'd1;
      end

      if (grant_w) begin
        err_reg <= 1'b0;
      end else if (state_reg == ST_WRITE && ram_error_i) begin
        err_reg <= 1'b1;
      end

      // A free and a take in the same cycle cancel; frees beyond capacity are dropped.
      if (rd_take && !rd_free_i) begin
        credits_reg <= credits_reg - CW'(1);
      end else if (!rd_take && rd_free_i && credits_reg != CW'(RD_CREDITS)) begin
        credits_reg <= credits_reg + CW'(1);
      end
    end
  end

  assign axi_bresp_o  = err_reg ? 2'b10 : 2'b00;
  assign axi_bid_o    = id_reg;
  assign ram_req_id_o = id_reg;
  assign ram_addr_o   = addr_reg;

endmodule

// File: tb/tb_ddr3_axi_sched.sv
// Bench for ddr3_axi_sched: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based transaction model.
module tb_ddr3_axi_sched;

  localparam int W   = 32;
  localparam int RDC = 6;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef DDR3_SCHED_WRITE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         awvalid, awready, arvalid, arready;
  logic [W-1:0] awaddr, araddr;
  logic [3:0]   awid, arid;
  logic [7:0]   awlen, arlen;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [3:0]   bid;
  logic         wdat_ready, rd_free, wren, rden, accept, rerr;
  logic [3:0]   req_id;
  logic [W-1:0] ram_addr;

  always #5 clock = ~clock;

  ddr3_axi_sched #(.WIDTH(W), .RD_CREDITS(RDC)) dut (
    .clock(clock), .reset(reset),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready), .axi_awaddr_i(awaddr),
    .axi_awid_i(awid), .axi_awlen_i(awlen),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bresp_o(bresp), .axi_bid_o(bid),
    .wdat_ready_i(wdat_ready), .rd_free_i(rd_free),
    .ram_wren_o(wren), .ram_rden_o(rden), .ram_accept_i(accept), .ram_error_i(rerr),
    .ram_req_id_o(req_id), .ram_addr_o(ram_addr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    awvalid = 0; awaddr = '0; awid = '0; awlen = '0;
    arvalid = 0; araddr = '0; arid = '0; arlen = '0;
    bready = 0; wdat_ready = 0; rd_free = 0; accept = 0; rerr = 0;
  endtask

  // ---------------- transaction-level reference model ----------------
  int           m_kind;      // 0 none, 1 write burst, 2 read burst
  logic [W-1:0] m_q[$];      // remaining command addresses of the active burst
  bit           m_resp, m_err, m_last_w;
  logic [3:0]   m_id, m_bid;
  int           m_cred;

  task automatic model_reset();
    m_kind = 0; m_q.delete(); m_resp = 0; m_err = 0; m_last_w = 0;
    m_id = '0; m_bid = '0; m_cred = RDC;
  endtask

  task automatic model_fill(input logic [W-1:0] a, input logic [7:0] len);
    logic [W-1:0] base;
    int n;
    base = a & 32'hFFFF_FFF0;
    n = ((int'(a[3:2]) + int'(len)) / 4) + 1;
    for (int i = 0; i < n; i++) m_q.push_back(base + W'(16 * i));
  endtask

  task automatic model_step();
    bit idle, gw, gr, e_wren, e_rden, fire, was_w, was_r, was_resp;
    idle   = (m_kind == 0) && !m_resp;
    gw     = idle && awvalid && (!arvalid || PRIO || !m_last_w);
    gr     = idle && arvalid && !gw;
    e_wren = (m_kind == 1) && wdat_ready;
    e_rden = (m_kind == 2) && (m_cred != 0);
    chk("rnd.awready", 32'(awready), 32'(gw));
    chk("rnd.arready", 32'(arready), 32'(gr));
    chk("rnd.wren", 32'(wren), 32'(e_wren));
    chk("rnd.rden", 32'(rden), 32'(e_rden));
    chk("rnd.bvalid", 32'(bvalid), 32'(m_resp));
    if (m_resp) begin
      chk("rnd.bresp", 32'(bresp), m_err ? 32'd2 : 32'd0);
      chk("rnd.bid", 32'(bid), 32'(m_bid));
    end
    if (e_wren || e_rden) begin
      chk("rnd.addr", ram_addr, m_q[0]);
      chk("rnd.req_id", 32'(req_id), 32'(m_id));
    end
    fire = (e_wren || e_rden) && accept;
    was_w = (m_kind == 1); was_r = (m_kind == 2); was_resp = m_resp;
    if (was_w && rerr) m_err = 1;
    if (fire) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (was_w) m_resp = 1;
        m_kind = 0;
      end
    end
    if (was_resp && bready) m_resp = 0;
    if (fire && was_r && !rd_free) m_cred--;
    else if (!(fire && was_r) && rd_free && m_cred < RDC) m_cred++;
    if (gw) begin
      model_fill(awaddr, awlen); m_kind = 1; m_id = awid; m_bid = awid; m_err = 0; m_last_w = 1;
    end else if (gr) begin
      model_fill(araddr, arlen); m_kind = 2; m_id = arid; m_last_w = 0;
    end
  endtask

  task automatic do_reset(input int n);
    clr_inputs();
    reset = 1;
    repeat (n) @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".awready"}, 32'(awready), 0);
    chk({tag, ".arready"}, 32'(arready), 0);
    chk({tag, ".wren"}, 32'(wren), 0);
    chk({tag, ".rden"}, 32'(rden), 0);
    chk({tag, ".bvalid"}, 32'(bvalid), 0);
    chk({tag, ".bresp"}, 32'(bresp), 0);
    chk({tag, ".bid"}, 32'(bid), 0);
    chk({tag, ".req_id"}, 32'(req_id), 0);
    chk({tag, ".addr"}, ram_addr, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic awv, arv; logic [31:0] a; logic [3:0] id; logic [7:0] len;
    logic wrdy, acc, brdy, err, free;
    logic e_awr, e_arr, e_wren, e_rden, e_bv; logic [1:0] e_bresp; logic [3:0] e_bid;
    logic [31:0] e_addr; logic [3:0] e_rid;
  } vec_t;

  vec_t vt[16];
  bit   grants[$];

  initial begin
    //            awv arv a         id len  wrdy acc brdy err free  awr arr wren rden bv  bresp bid eaddr     rid
    vt[0]  = '{H, L, 32'h100, 4'd3, 8'd15, H, H, L, L, L,  H, L, L, L, L, 2'd0, 4'd0, 32'h000, 4'd0};
    vt[1]  = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h100, 4'd3};
    vt[2]  = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h110, 4'd3};
    vt[3]  = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h120, 4'd3};
    vt[4]  = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h130, 4'd3};
    vt[5]  = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, L, L, H, 2'd0, 4'd3, 32'h000, 4'd0};
    vt[6]  = '{L, L, 32'h000, 4'd0, 8'd0,  L, L, H, L, L,  L, L, L, L, H, 2'd0, 4'd3, 32'h000, 4'd0};
    vt[7]  = '{L, H, 32'h20C, 4'd5, 8'd4,  L, L, L, L, L,  L, H, L, L, L, 2'd0, 4'd0, 32'h000, 4'd0};
    vt[8]  = '{L, L, 32'h000, 4'd0, 8'd0,  L, H, L, L, L,  L, L, L, H, L, 2'd0, 4'd0, 32'h200, 4'd5};
    vt[9]  = '{L, L, 32'h000, 4'd0, 8'd0,  L, H, L, L, L,  L, L, L, H, L, 2'd0, 4'd0, 32'h210, 4'd5};
    vt[10] = '{H, L, 32'h3F8, 4'd9, 8'd1,  H, H, L, L, L,  H, L, L, L, L, 2'd0, 4'd0, 32'h000, 4'd0};
    vt[11] = '{L, L, 32'h000, 4'd0, 8'd0,  L, H, L, L, L,  L, L, L, L, L, 2'd0, 4'd0, 32'h000, 4'd0};
    vt[12] = '{L, L, 32'h000, 4'd0, 8'd0,  H, L, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h3F0, 4'd9};
    vt[13] = '{L, L, 32'h000, 4'd0, 8'd0,  H, H, L, L, L,  L, L, H, L, L, 2'd0, 4'd0, 32'h3F0, 4'd9};
    vt[14] = '{L, L, 32'h000, 4'd0, 8'd0,  L, L, H, L, L,  L, L, L, L, H, 2'd0, 4'd9, 32'h000, 4'd0};
    vt[15] = '{L, L, 32'h000, 4'd0, 8'd0,  L, L, L, L, L,  L, L, L, L, L, 2'd0, 4'd0, 32'h000, 4'd0};

    // Reset state
    do_reset(3);
    settle();
    chk_all_zero("reset");
    adv();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      awvalid = vt[i].awv; awaddr = vt[i].a; awid = vt[i].id; awlen = vt[i].len;
      arvalid = vt[i].arv; araddr = vt[i].a; arid = vt[i].id; arlen = vt[i].len;
      wdat_ready = vt[i].wrdy; accept = vt[i].acc; bready = vt[i].brdy;
      rerr = vt[i].err; rd_free = vt[i].free;
      settle();
      chk($sformatf("vec%0d.awready", i), 32'(awready), 32'(vt[i].e_awr));
      chk($sformatf("vec%0d.arready", i), 32'(arready), 32'(vt[i].e_arr));
      chk($sformatf("vec%0d.wren", i), 32'(wren), 32'(vt[i].e_wren));
      chk($sformatf("vec%0d.rden", i), 32'(rden), 32'(vt[i].e_rden));
      chk($sformatf("vec%0d.bvalid", i), 32'(bvalid), 32'(vt[i].e_bv));
      if (vt[i].e_bv) begin
        chk($sformatf("vec%0d.bresp", i), 32'(bresp), 32'(vt[i].e_bresp));
        chk($sformatf("vec%0d.bid", i), 32'(bid), 32'(vt[i].e_bid));
      end
      if (vt[i].e_wren || vt[i].e_rden) begin
        chk($sformatf("vec%0d.addr", i), ram_addr, vt[i].e_addr);
        chk($sformatf("vec%0d.req_id", i), 32'(req_id), 32'(vt[i].e_rid));
      end
      adv();
    end

    // Contested arbitration: single-command bursts on both sides
    do_reset(2);
    awvalid = 1; arvalid = 1; awaddr = 32'h40; araddr = 32'h80; awlen = 0; arlen = 0;
    wdat_ready = 1; accept = 1; bready = 1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (awready) grants.push_back(1'b1);
      if (arready) grants.push_back(1'b0);
      adv();
    end
    chk("arb.count", 32'(grants.size() >= 4), 1);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      chk($sformatf("arb.grant%0d", g), 32'(grants[g]), (PRIO || g % 2 == 0) ? 32'd1 : 32'd0);

    // Read credit exhaustion and replenishment: 12-command read, no frees at first
    do_reset(2);
    arvalid = 1; araddr = 32'h0; arlen = 8'd47; arid = 4'd2; accept = 1;
    settle(); chk("cred.arready", 32'(arready), 1); adv();
    arvalid = 0;
    for (int k = 0; k < RDC; k++) begin
      settle(); chk($sformatf("cred.rden%0d", k), 32'(rden), 1);
      chk($sformatf("cred.addr%0d", k), ram_addr, 32'(16 * k)); adv();
    end
    settle(); chk("cred.empty0", 32'(rden), 0); adv();
    rd_free = 1;
    settle(); chk("cred.empty1", 32'(rden), 0); adv();
    rd_free = 0;
    settle(); chk("cred.one", 32'(rden), 1); chk("cred.one_addr", ram_addr, 32'h60); adv();
    rd_free = 1;
    settle(); chk("cred.empty2", 32'(rden), 0); adv();
    settle(); chk("cred.both", 32'(rden), 1); chk("cred.both_addr", ram_addr, 32'h70); adv();
    rd_free = 0;
    settle(); chk("cred.kept", 32'(rden), 1); chk("cred.kept_addr", ram_addr, 32'h80); adv();
    settle(); chk("cred.empty3", 32'(rden), 0); adv();

    // Error flag: strobe during the 2nd of 3 write commands, then a clean write
    do_reset(2);
    awvalid = 1; awaddr = 32'h0; awlen = 8'd11; awid = 4'd7; wdat_ready = 1; accept = 1;
    settle(); chk("err.awready", 32'(awready), 1); adv();
    awvalid = 0;
    settle(); chk("err.wren1", 32'(wren), 1); adv();
    rerr = 1;
    settle(); chk("err.wren2", 32'(wren), 1); adv();
    rerr = 0;
    settle(); chk("err.wren3", 32'(wren), 1); chk("err.addr3", ram_addr, 32'h20); adv();
    bready = 1;
    settle(); chk("err.bvalid", 32'(bvalid), 1); chk("err.bresp", 32'(bresp), 2);
    chk("err.bid", 32'(bid), 7); adv();
    awvalid = 1; awaddr = 32'h40; awlen = 8'd0; awid = 4'd8;
    settle(); chk("err.awready2", 32'(awready), 1); adv();
    awvalid = 0;
    settle(); chk("err.wren4", 32'(wren), 1); chk("err.addr4", ram_addr, 32'h40); adv();
    settle(); chk("err.bvalid2", 32'(bvalid), 1); chk("err.bresp2", 32'(bresp), 0);
    chk("err.bid2", 32'(bid), 8); adv();

    // Reset in the middle of a 4-command write
    bready = 0;
    awvalid = 1; awaddr = 32'h500; awlen = 8'd15; awid = 4'd4; wdat_ready = 1; accept = 1;
    settle(); chk("rst.awready", 32'(awready), 1); adv();
    awvalid = 0;
    settle(); chk("rst.wren", 32'(wren), 1); chk("rst.addr", ram_addr, 32'h500); adv();
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      settle(); chk_all_zero($sformatf("rst.after%0d", c)); adv();
    end

    // Random traffic against the model
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      awvalid = ($urandom_range(0, 99) < 30);
      arvalid = ($urandom_range(0, 99) < 30);
      awaddr = $urandom; araddr = $urandom;
      awid = 4'($urandom_range(0, 15)); arid = 4'($urandom_range(0, 15));
      awlen = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      arlen = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      wdat_ready = ($urandom_range(0, 99) < 70);
      accept = ($urandom_range(0, 99) < 70);
      bready = ($urandom_range(0, 99) < 50);
      rerr = ($urandom_range(0, 99) < 10);
      rd_free = ($urandom_range(0, 99) < 30);
      settle();
      model_step();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_axi_sched.md
# ddr3_axi_sched

Command scheduler between the AXI4 address channels and the DDR3 memory-controller command port. It accepts one AXI write-address or read-address burst at a time and arbitrates between them. Each burst is split into 16-byte (128-bit) memory commands, with writes gated on write-data availability and reads gated on read-data FIFO credits. It also generates the AXI write response, and sits between the AXI slave port and the memory-controller command interface.

## Interface

Parameters:
- WIDTH, 32: AXI address width; the AXI data beat is 32 bits.
- RD_CREDITS, 128: number of 128-bit chunks the read-data FIFO holds.

Ports (clock, reset first):
- clock  in  1  system clock; every signal is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- axi_awvalid_i  in  1  write-address valid.
- axi_awready_o  out  1  write-address accept.
- axi_awaddr_i  in  WIDTH  write byte address.
- axi_awid_i  in  4  write ID.
- axi_awlen_i  in  8  write beats minus 1.
- axi_arvalid_i / axi_arready_o / axi_araddr_i / axi_arid_i / axi_arlen_i: read-address equivalents of the five write-address ports.
- axi_bvalid_o  out  1  write response valid.
- axi_bready_i  in  1  write response ready.
- axi_bresp_o  out  2  write response: 00 OKAY, 10 SLVERR.
- axi_bid_o  out  4  write response ID.
- wdat_ready_i  in  1  at least one full 128-bit chunk is present in the write-data FIFO.
- rd_free_i  in  1  one 128-bit chunk was popped from the read-data FIFO.
- ram_wren_o  out  1  write command valid.
- ram_rden_o  out  1  read command valid.
- ram_accept_i  in  1  controller accepts the presented command.
- ram_error_i  in  1  controller error strobe.
- ram_req_id_o  out  4  ID of the current burst.
- ram_addr_o  out  WIDTH  16-byte-aligned command address; bits [3:0] are always 0.

## Operation

- FSM states and transitions:
  - ST_IDLE: on grant, go to ST_WRITE or ST_READ.
  - ST_WRITE: after the last write command is accepted, go to ST_BRESP.
  - ST_BRESP: when bvalid && bready, go to ST_IDLE.
  - ST_READ: after the last read command is accepted, go to ST_IDLE.
- Arbitration in ST_IDLE:
  - If only one of awvalid/arvalid is high, that request is granted.
  - If both are high, the side not granted last time wins (round-robin). last_grant updates on every grant.
- On grant:
  - Assert the matching axi_*ready_o in that same cycle; it is combinational from state and valid.
  - Latch {addr[WIDTH-1:4], 4'b0}, id, and the command count.
- Command count = ((addr[3:2] + len) >> 2) + 1, computed 10 bits wide; range 1..65. Only INCR bursts are supported.
- In ST_WRITE: ram_wren_o = wdat_ready_i. In ST_READ: ram_rden_o = (credits != 0).
- On each accepted command (valid && ram_accept_i):
  - Address increments by 16, modulo 2^WIDTH.
  - Count decrements by 1.
  - The move to the next state happens when count reaches 0.
- Read credit counter, width clog2(RD_CREDITS+1):
  - Decrements on each accepted read command; increments on rd_free_i.
  - If both occur in the same cycle, it is unchanged.
  - Never exceeds RD_CREDITS; an rd_free_i at full credit is ignored.
- Error flag:
  - Cleared on write grant; set by ram_error_i during ST_WRITE.
  - axi_bresp_o = err ? 2'b10 : 2'b00.
  - axi_bid_o = the latched awid.
- Reset values:
  - All outputs are 0 (ram_addr_o and ram_req_id_o included).
  - State is ST_IDLE; credits = RD_CREDITS.
  - last_grant = read, so the first contested grant goes to write.
- Reset during a burst abandons it immediately; no bvalid is issued.

## Timing

- Address handshake to first command valid: 1 cycle. The command is registered, so it is visible in the cycle after the ready pulse.
- Commands can be issued back-to-back, one per cycle, while ram_accept_i, wdat_ready_i and credits allow.
- ram_addr_o and ram_req_id_o are stable while a command is valid and not yet accepted.
- Last write accept to axi_bvalid_o high: 1 cycle. bvalid holds until bready.
- ST_READ to ST_IDLE: 1 cycle after the last accept. A new grant can occur in that ST_IDLE cycle.
- Minimum grant-to-grant spacing:
  - Single-command read: 2 cycles.
  - Single-command write: 3 cycles when bready is held high.

## Configuration

- DDR3_SCHED_WRITE_PRIORITY_EN:
  - Defined: a write wins whenever both awvalid and arvalid are high in ST_IDLE; last_grant is ignored.
  - Undefined: round-robin as described in Operation.

## Test plan

- Write awaddr=0x100, awlen=15, id=3, wdat_ready_i held high, ram_accept_i high -> 4 wren pulses at 0x100/0x110/0x120/0x130, then bvalid with bid=3, bresp=00.
- Read araddr=0x20C, arlen=4 -> count = ((3+4)>>2)+1 = 2; rden at 0x200 and 0x210; credits drop from 128 to 126.
- awvalid and arvalid both high continuously, each burst 1 command -> grants alternate W,R,W,R starting with W; with the macro defined, W only.
- RD_CREDITS=2 and a read of 4 commands with no rd_free_i -> rden deasserts after 2 accepts; one rd_free_i pulse -> exactly 1 more command; rd_free_i coinciding with an accept -> credit count unchanged.
- ram_error_i pulsed during the 2nd of 3 write commands -> bresp=10; the next write burst returns 00.
- reset asserted mid-write after 1 of 4 accepts -> next cycle: all outputs 0, ST_IDLE, credits=RD_CREDITS, no bvalid.
